vlib_adder_tree_acc: RTL and testbench

Parametrised, pipelined signed adder tree with a group accumulator for the DLA datapath.
- Each accepted beat reduces NUM_IN signed operands to one partial sum.
- Partial sums of consecutive beats are accumulated until a beat flagged IN_LAST; the group total is then presented on a valid/ready output.
- Sits between the multiplier array and the output/requantisation stage.

---
 rtl/vlib_pkg.sv | 27 ++
 rtl/vlib_adder_level.sv | 46 ++++
 rtl/vlib_adder_tree_acc.sv | 127 ++++++++++++
 tb/tb_vlib_adder_tree_acc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vlib_pkg.sv
// Shared types and helpers for the vlib adder tree: level count, per-level widths,
// accumulator saturation limits and the per-stage valid/last sideband.
package vlib_pkg;

   typedef struct packed {
      logic valid;
      logic last;
   } sb_t;

   function automatic int num_levels(input int n);
      return $clog2(n);
   endfunction

   // Each pairwise level grows the operand by one bit, so no sum is ever truncated.
   function automatic int level_width(input int bw, input int k);
      return bw + k;
   endfunction

   function automatic logic [63:0] sat_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_neg(input int w);
      return ~sat_pos(w);
   endfunction

endpackage

// File: rtl/vlib_adder_level.sv
// One registered adder-tree level: sums adjacent signed pairs, one bit wider out,
// and carries the beat's valid/last sideband alongside.
module vlib_adder_level
   import vlib_pkg::*;
#(
   parameter int PAIRS = 4,
   parameter int IN_W  = 16
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      i_stall,
   input  logic [2*PAIRS*IN_W-1:0]   i_data,
   input  sb_t                       i_sb,
   output logic [PAIRS*(IN_W+1)-1:0] o_data,
   output sb_t                       o_sb
);

   localparam int OUT_W = IN_W + 1;

   logic [PAIRS*OUT_W-1:0] w_sum;
   logic [PAIRS*OUT_W-1:0] r_data;
   sb_t                    r_sb;

   always_comb begin
      w_sum = '0;
      for (int p = 0; p < PAIRS; p++) begin
         w_sum[p*OUT_W +: OUT_W] =
            {i_data[2*p*IN_W + IN_W - 1], i_data[2*p*IN_W +: IN_W]} +
            {i_data[(2*p+1)*IN_W + IN_W - 1], i_data[(2*p+1)*IN_W +: IN_W]};
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_data <= '0;
         r_sb   <= '0;
      end else if (!i_stall) begin
         r_data <= w_sum;
         r_sb   <= i_sb;
      end
   end

   assign o_data = r_data;
   assign o_sb   = r_sb;

endmodule

// File: rtl/vlib_adder_tree_acc.sv
// Pipelined signed adder tree with per-group accumulator and valid/ready output.
// Optional saturation instead of wrap: define VLIB_ADDER_TREE_SAT_EN.
module vlib_adder_tree_acc
   import vlib_pkg::*;
#(
   parameter int BITWIDTH  = 16,
   parameter int NUM_IN    = 8,
   parameter int ACC_WIDTH = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [NUM_IN*BITWIDTH-1:0] IN_DATA,
   input  logic                       IN_LAST,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [ACC_WIDTH-1:0]       OUT_DATA,
   output logic                       OUT_OVF
);

   localparam int L   = num_levels(NUM_IN);
   localparam int TW  = level_width(BITWIDTH, L);
   localparam int MSB = ACC_WIDTH - 1;

   logic                 w_stall;
   logic                 w_in_ready;
   logic [TW-1:0]        w_tree;
   sb_t                  w_tree_sb;
   logic [ACC_WIDTH-1:0] w_ext;
   logic [ACC_WIDTH-1:0] w_sum;
   logic [ACC_WIDTH-1:0] w_new;
   logic                 w_ovf;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_grp_ovf;
   logic                 r_out_valid;
   logic [ACC_WIDTH-1:0] r_out_data;
   logic                 r_out_ovf;

   // A pending result nobody takes freezes the whole pipeline, accumulator included.
   assign w_stall    = r_out_valid & ~OUT_READY;
   assign w_in_ready = ~w_stall;

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int PAIRS = NUM_IN >> (k + 1);
      localparam int IW    = level_width(BITWIDTH, k);

      logic [2*PAIRS*IW-1:0]   w_in;
      sb_t                     w_sb_in;
      logic [PAIRS*(IW+1)-1:0] w_out;
      sb_t                     w_sb_out;

      if (k == 0) begin : g_first
         assign w_in    = IN_DATA;
         assign w_sb_in = '{valid: IN_VALID & w_in_ready, last: IN_LAST};
      end else begin : g_next
         assign w_in    = g_lvl[k-1].w_out;
         assign w_sb_in = g_lvl[k-1].w_sb_out;
      end

      vlib_adder_level #(
         .PAIRS (PAIRS),
         .IN_W  (IW)
      ) u_level (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .i_stall (w_stall),
         .i_data  (w_in),
         .i_sb    (w_sb_in),
         .o_data  (w_out),
         .o_sb    (w_sb_out)
      );
   end

   assign w_tree    = g_lvl[L-1].w_out;
   assign w_tree_sb = g_lvl[L-1].w_sb_out;

`ifdef VLIB_ADDER_TREE_SAT_EN
   localparam logic [ACC_WIDTH-1:0] SAT_POS = ACC_WIDTH'(sat_pos(ACC_WIDTH));
   localparam logic [ACC_WIDTH-1:0] SAT_NEG = ACC_WIDTH'(sat_neg(ACC_WIDTH));
`endif

   always_comb begin
      w_ext = ACC_WIDTH'($signed(w_tree));
      w_sum = r_acc + w_ext;
      w_ovf = (r_acc[MSB] == w_ext[MSB]) && (w_sum[MSB] != r_acc[MSB]);
`ifdef VLIB_ADDER_TREE_SAT_EN
      // Once clamped, the accumulator stays pinned until the group closes.
      if (r_grp_ovf)  w_new = r_acc;
      else if (w_ovf) w_new = w_ext[MSB] ? SAT_NEG : SAT_POS;
      else            w_new = w_sum;
`else
      w_new = w_sum;
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_acc       <= '0;
         r_grp_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= 1'b0;
         if (w_tree_sb.valid) begin
            if (w_tree_sb.last) begin
               r_out_data  <= w_new;
               r_out_ovf   <= r_grp_ovf | w_ovf;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_grp_ovf   <= 1'b0;
            end else begin
               r_acc       <= w_new;
               r_grp_ovf   <= r_grp_ovf | w_ovf;
            end
         end
      end
   end

   assign IN_READY  = w_in_ready;
   assign OUT_VALID = r_out_valid;
   assign OUT_DATA  = r_out_data;
   assign OUT_OVF   = r_out_ovf;

endmodule

// File: tb/tb_vlib_adder_tree_acc.sv
// Directed bench for vlib_adder_tree_acc: a 32-bit and a 20-bit accumulator instance
// share stimulus; results are checked in order against hand-computed group sums.
module tb_vlib_adder_tree_acc;

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic               IN_VALID = 1'b0;
   logic [127:0]       IN_DATA = '0;
   logic               IN_LAST = 1'b0;
   logic               OUT_READY = 1'b1;
   logic               IN_READY, IN_READY20;
   logic               OUT_VALID, OUT_VALID20;
   logic signed [31:0] OUT_DATA;
   logic signed [19:0] OUT_DATA20;
   logic               OUT_OVF, OUT_OVF20;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      longint d32;
      longint d20;
      bit     o20;
   } exp_t;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   vlib_adder_tree_acc #(.BITWIDTH(16), .NUM_IN(8), .ACC_WIDTH(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_OVF(OUT_OVF));

   vlib_adder_tree_acc #(.BITWIDTH(16), .NUM_IN(8), .ACC_WIDTH(20)) dut20 (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY20),
      .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .OUT_VALID(OUT_VALID20),
      .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA20), .OUT_OVF(OUT_OVF20));

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rep(input logic [15:0] v);
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[i*16 +: 16] = v;
      return d;
   endfunction

   // Drive one beat #1 after a rising edge; returns #1 after the edge that accepted it.
   task automatic send(input logic [127:0] d, input logic last, input bit push,
                       input longint e32, input longint e20, input bit o20);
      int n = 0;
      exp_t e;
      IN_VALID = 1'b1;
      IN_DATA  = d;
      IN_LAST  = last;
      @(negedge CLK);
      while (!IN_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) check_eq("in_ready_timeout", 0, 1);
      if (last && push) begin
         e.d32 = e32; e.d20 = e20; e.o20 = o20;
         exp_q.push_back(e);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_LAST  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || OUT_VALID) && n < 40) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check_eq("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Output monitor: a transfer happens on the edge following a negedge with valid & ready.
   always @(negedge CLK) begin
      if (RST_N && OUT_VALID === 1'b1 && OUT_READY) begin
         check_eq("valid_20_matches", OUT_VALID20, 1);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_result", OUT_DATA, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("out_data_32", OUT_DATA, e.d32);
            check_eq("out_ovf_32", OUT_OVF, 0);
            check_eq("out_data_20", OUT_DATA20, e.d20);
            check_eq("out_ovf_20", OUT_OVF20, e.o20);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] mix;
      int           mixv[8] = '{1, -2, 3, -4, 5, -6, 7, -8};
      int           n;
      longint       e20_ovf;

      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_out_valid", OUT_VALID, 0);
      check_eq("rst_out_data", OUT_DATA, 0);
      check_eq("rst_out_ovf", OUT_OVF, 0);
      RST_N = 1'b1;
      #1;
      check_eq("rst_in_ready", IN_READY, 1);
      @(posedge CLK);
      #1;

      // Single beat of ones, with latency measured from the accepting edge.
      send(rep(16'd1), 1'b1, 1'b1, 8, 8, 1'b0);
      n = 1;
      while (!OUT_VALID && n < 20) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check_eq("latency_cycles", n, 4);
      drain();

      send(rep(16'h8000), 1'b1, 1'b1, -262144, -262144, 1'b0);
      for (int i = 0; i < 8; i++) mix[i*16 +: 16] = 16'(mixv[i]);
      send(mix, 1'b1, 1'b1, -4, -4, 1'b0);
      drain();

      // Three-beat group then a one-beat group: accumulator must restart from zero.
      send(rep(16'd100), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd100), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd100), 1'b1, 1'b1, 2400, 2400, 1'b0);
      send(rep(16'd1), 1'b1, 1'b1, 8, 8, 1'b0);
      drain();

      // Backpressure: hold a result for 5 cycles with a second group queued behind.
      OUT_READY = 1'b0;
      send(rep(16'd3), 1'b1, 1'b1, 24, 24, 1'b0);
      send(rep(16'd5), 1'b1, 1'b1, 40, 40, 1'b0);
      n = 0;
      while (!OUT_VALID && n < 20) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check_eq("stall_result_arrives", OUT_VALID, 1);
      for (int c = 0; c < 5; c++) begin
         check_eq("stall_in_ready", IN_READY, 0);
         check_eq("stall_out_data", OUT_DATA, 24);
         check_eq("stall_out_valid", OUT_VALID, 1);
         @(posedge CLK);
         #1;
      end
      OUT_READY = 1'b1;
      drain();

      // 20-bit accumulator: two beats fit exactly, three beats overflow.
`ifdef VLIB_ADDER_TREE_SAT_EN
      e20_ovf = 524287;
`else
      e20_ovf = -262168;
`endif
      send(rep(16'd32767), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd32767), 1'b1, 1'b1, 524272, 524272, 1'b0);
      send(rep(16'd32767), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd32767), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd32767), 1'b1, 1'b1, 786408, e20_ovf, 1'b1);
      send(rep(16'd1), 1'b1, 1'b1, 8, 8, 1'b0);
      drain();

      // Reset with the pipeline full, including a closing beat that must be discarded.
      send(rep(16'd7), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd7), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd7), 1'b0, 1'b0, 0, 0, 1'b0);
      send(rep(16'd9), 1'b1, 1'b0, 0, 0, 1'b0);
      RST_N = 1'b0;
      #1;
      check_eq("midrst_out_valid", OUT_VALID, 0);
      check_eq("midrst_out_data", OUT_DATA, 0);
      check_eq("midrst_out_ovf", OUT_OVF20, 0);
      check_eq("midrst_out_data_20", OUT_DATA20, 0);
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      send(rep(16'd2), 1'b1, 1'b1, 16, 16, 1'b0);
      drain();
      repeat (5) @(posedge CLK);
      #1;
      check_eq("final_idle", OUT_VALID, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
